exu_branchslv: RTL and testbench

- Branch resolution unit in the EXU. It is the consuming end of the IFU static predictor.
- For each committed B/J instruction it compares the IFU prediction (taken flag, JALR target) with the actual outcome.
- On a mismatch it raises a flush/redirect request to the IFU with a valid/ready handshake, and blocks further branch commits until the IFU accepts the request.
- It keeps saturating branch and mispredict counters for performance monitoring.

---
 rtl/exu_branchslv.sv | 125 ++++++++++++
 tb/tb_exu_branchslv.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/exu_branchslv.sv
// exu_branchslv: branch resolution unit at the EXU end of the IFU static predictor.
// Compares each committed B/J instruction against the IFU prediction, raises a
// flush/redirect request on a mispredict, and keeps saturating perf counters.
module exu_branchslv #(
   parameter int PC_SIZE = 32,
   parameter int CNT_W   = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               i_valid,
   output logic               i_ready,
   input  logic               i_bxx,
   input  logic               i_jal,
   input  logic               i_jalr,
   input  logic               i_prdt_taken,
   input  logic               i_cmp_res,
   input  logic [PC_SIZE-1:0] i_pc,
   input  logic [PC_SIZE-1:0] i_bjp_imm,
   input  logic               i_ilen32,
   input  logic [PC_SIZE-1:0] i_jalr_tgt,
   input  logic [PC_SIZE-1:0] i_prdt_tgt,
   input  logic               i_kill,
   output logic               flush_req_valid,
   input  logic               flush_req_ready,
   output logic [PC_SIZE-1:0] flush_pc,
   output logic               cmt_mispred,
   output logic [CNT_W-1:0]   br_cnt,
   output logic [CNT_W-1:0]   mispr_cnt
);

   typedef enum logic {
      IDLE  = 1'b0,
      FLUSH = 1'b1
   } state_e;

   state_e             state_q, state_d;
   logic [PC_SIZE-1:0] flush_pc_q, flush_pc_d;
   logic               cmt_mispred_q, cmt_mispred_d;
   logic [CNT_W-1:0]   br_cnt_q, br_cnt_d;
   logic [CNT_W-1:0]   mispr_cnt_q, mispr_cnt_d;

   logic               acc;
   logic               is_br;
   logic               mis;
   logic [PC_SIZE-1:0] tgt;
   logic [PC_SIZE-1:0] seq_step;
   logic [PC_SIZE-1:0] lsb_mask;

   // Commits are only taken while no redirect is outstanding and nothing is killing the pipe.
   assign i_ready = (state_q == IDLE) & ~i_kill;
   assign acc     = i_valid & i_ready;
   assign is_br   = i_bxx | i_jal | i_jalr;

   assign seq_step = i_ilen32 ? PC_SIZE'(4) : PC_SIZE'(2);
   assign lsb_mask = ~PC_SIZE'(1);

   // Resolve the branch outcome and the correct-path target for the committing instruction.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latches).
      mis = 1'b0;
      tgt = '0;
      if (i_bxx) begin
         mis = i_prdt_taken ^ i_cmp_res;
         tgt = i_cmp_res ? (i_pc + i_bjp_imm) : (i_pc + seq_step);
      end else if (i_jalr) begin
         // The IFU and the ALU may disagree on bit0; JALR always clears it, so it never counts.
         mis = (i_jalr_tgt & lsb_mask) != (i_prdt_tgt & lsb_mask);
         tgt = i_jalr_tgt & lsb_mask;
      end
      // JAL targets are fully known at fetch, so it never mispredicts.
   end

   // Next-state, redirect capture and counter update.
   always_comb begin
      state_d       = state_q;
      flush_pc_d    = flush_pc_q;
      cmt_mispred_d = 1'b0;
      br_cnt_d      = br_cnt_q;
      mispr_cnt_d   = mispr_cnt_q;

      unique case (state_q)
         IDLE: begin
            if (acc && is_br) begin
               if (br_cnt_q != '1) br_cnt_d = br_cnt_q + CNT_W'(1);
               if (mis) begin
                  state_d       = FLUSH;
                  flush_pc_d    = tgt;
                  cmt_mispred_d = 1'b1;
                  if (mispr_cnt_q != '1) mispr_cnt_d = mispr_cnt_q + CNT_W'(1);
               end
            end
         end
         FLUSH: begin
            // A kill owns the redirect itself, so ours is dropped; it also wins over ready.
            if (i_kill || flush_req_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update from the same pre-edge values.
      if (rst) begin
         state_q       <= IDLE;
         flush_pc_q    <= '0;
         cmt_mispred_q <= 1'b0;
         br_cnt_q      <= '0;
         mispr_cnt_q   <= '0;
      end else begin
         state_q       <= state_d;
         flush_pc_q    <= flush_pc_d;
         cmt_mispred_q <= cmt_mispred_d;
         br_cnt_q      <= br_cnt_d;
         mispr_cnt_q   <= mispr_cnt_d;
      end
   end

   assign flush_req_valid = (state_q == FLUSH);
   assign flush_pc        = flush_pc_q;
   assign cmt_mispred     = cmt_mispred_q;
   assign br_cnt          = br_cnt_q;
   assign mispr_cnt       = mispr_cnt_q;

endmodule

// File: tb/tb_exu_branchslv.sv
// tb_exu_branchslv: directed scenarios followed by randomized traffic, all checked
// against a cycle-level behavioural model of the branch resolution rules.
module tb_exu_branchslv;

   localparam int PC_SIZE = 32;
   // Counters are width-generic; a narrow width makes saturation reachable quickly.
   localparam int CNT_W   = 10;
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic               clk = 1'b0;
   logic               rst;
   logic               i_valid, i_ready;
   logic               i_bxx, i_jal, i_jalr;
   logic               i_prdt_taken, i_cmp_res;
   logic [PC_SIZE-1:0] i_pc, i_bjp_imm;
   logic               i_ilen32;
   logic [PC_SIZE-1:0] i_jalr_tgt, i_prdt_tgt;
   logic               i_kill;
   logic               flush_req_valid, flush_req_ready;
   logic [PC_SIZE-1:0] flush_pc;
   logic               cmt_mispred;
   logic [CNT_W-1:0]   br_cnt, mispr_cnt;

   exu_branchslv #(.PC_SIZE(PC_SIZE), .CNT_W(CNT_W)) dut (
      .clk            (clk),
      .rst            (rst),
      .i_valid        (i_valid),
      .i_ready        (i_ready),
      .i_bxx          (i_bxx),
      .i_jal          (i_jal),
      .i_jalr         (i_jalr),
      .i_prdt_taken   (i_prdt_taken),
      .i_cmp_res      (i_cmp_res),
      .i_pc           (i_pc),
      .i_bjp_imm      (i_bjp_imm),
      .i_ilen32       (i_ilen32),
      .i_jalr_tgt     (i_jalr_tgt),
      .i_prdt_tgt     (i_prdt_tgt),
      .i_kill         (i_kill),
      .flush_req_valid(flush_req_valid),
      .flush_req_ready(flush_req_ready),
      .flush_pc       (flush_pc),
      .cmt_mispred    (cmt_mispred),
      .br_cnt         (br_cnt),
      .mispr_cnt      (mispr_cnt)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state: is a redirect outstanding, and what the outputs should read.
   bit               m_busy;
   logic [PC_SIZE-1:0] m_pc;
   bit               m_pulse;
   int               m_br, m_mis;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic int sat_inc(input int v);
      return (v >= int'(CNT_MAX)) ? v : v + 1;
   endfunction

   task automatic clear_inputs();
      i_valid = 0; i_bxx = 0; i_jal = 0; i_jalr = 0;
      i_prdt_taken = 0; i_cmp_res = 0; i_pc = '0; i_bjp_imm = '0;
      i_ilen32 = 0; i_jalr_tgt = '0; i_prdt_tgt = '0; i_kill = 0;
   endtask

   // One clock: check combinational outputs, advance the model, check registered outputs.
   task automatic cycle();
      bit mis;
      logic [PC_SIZE-1:0] tgt;
      #1;
      check("i_ready", i_ready, !m_busy && !i_kill);
      check("valid_pre", flush_req_valid, m_busy);

      mis = 0;
      tgt = '0;
      if (rst) begin
         m_busy = 0; m_pc = '0; m_pulse = 0; m_br = 0; m_mis = 0;
      end else if (m_busy) begin
         m_pulse = 0;
         if (i_kill || flush_req_ready) m_busy = 0;
      end else begin
         m_pulse = 0;
         if (i_valid && !i_kill && (i_bxx || i_jal || i_jalr)) begin
            m_br = sat_inc(m_br);
            if (i_bxx) begin
               mis = (i_prdt_taken != i_cmp_res);
               tgt = i_cmp_res ? i_pc + i_bjp_imm : i_pc + (i_ilen32 ? 32'd4 : 32'd2);
            end else if (i_jalr) begin
               mis = (i_jalr_tgt >> 1) != (i_prdt_tgt >> 1);
               tgt = {i_jalr_tgt[PC_SIZE-1:1], 1'b0};
            end
            if (mis) begin
               m_busy = 1; m_pc = tgt; m_pulse = 1; m_mis = sat_inc(m_mis);
            end
         end
      end

      @(posedge clk);
      #1;
      check("flush_req_valid", flush_req_valid, m_busy);
      check("flush_pc", flush_pc, m_pc);
      check("cmt_mispred", cmt_mispred, m_pulse);
      check("br_cnt", br_cnt, m_br);
      check("mispr_cnt", mispr_cnt, m_mis);
      @(negedge clk);
   endtask

   // Issue one branch for a single cycle, check the redirect against a hand value, then drain.
   task automatic do_br(input int kind, input logic [31:0] pc, input logic [31:0] imm,
                        input bit ilen, input bit prdt, input bit cmp,
                        input logic [31:0] jt, input logic [31:0] pt,
                        input bit exp_flush, input logic [31:0] exp_pc);
      clear_inputs();
      i_valid = 1;
      i_bxx = (kind == 0); i_jal = (kind == 1); i_jalr = (kind == 2);
      i_pc = pc; i_bjp_imm = imm; i_ilen32 = ilen;
      i_prdt_taken = prdt; i_cmp_res = cmp; i_jalr_tgt = jt; i_prdt_tgt = pt;
      flush_req_ready = 0;
      cycle();
      check("dir_flush", flush_req_valid, exp_flush);
      if (exp_flush) check("dir_pc", flush_pc, exp_pc);
      clear_inputs();
      flush_req_ready = 1;
      cycle();
      flush_req_ready = 0;
   endtask

   initial begin
      clear_inputs();
      flush_req_ready = 0;
      rst = 1;
      m_busy = 0; m_pc = '0; m_pulse = 0; m_br = 0; m_mis = 0;
      @(negedge clk);
      cycle();
      cycle();
      rst = 0;
      check("rst_valid", flush_req_valid, 1'b0);
      check("rst_br_cnt", br_cnt, '0);

      // Correctly predicted taken Bxx: counted, no redirect.
      do_br(0, 32'h100, 32'hFFFF_FFF0, 1, 1, 1, 0, 0, 0, 0);
      check("t1_br_cnt", br_cnt, 1);
      check("t1_mispr_cnt", mispr_cnt, 0);

      // Mispredicted taken Bxx, IFU stalls ready for three cycles.
      clear_inputs();
      i_valid = 1; i_bxx = 1; i_pc = 32'h200; i_bjp_imm = 32'h40; i_prdt_taken = 0; i_cmp_res = 1;
      cycle();
      check("t2_pulse", cmt_mispred, 1'b1);
      check("t2_pc", flush_pc, 32'h240);
      clear_inputs();
      i_valid = 1; i_bxx = 1;
      for (int k = 0; k < 3; k++) begin
         cycle();
         check("t2_hold_pc", flush_pc, 32'h240);
         check("t2_hold_valid", flush_req_valid, 1'b1);
      end
      clear_inputs();
      flush_req_ready = 1;
      cycle();
      flush_req_ready = 0;
      check("t2_idle", flush_req_valid, 1'b0);
      check("t2_mispr_cnt", mispr_cnt, 1);

      // Not-taken fall-through targets and address wrap.
      do_br(0, 32'h300, 32'h80, 0, 1, 0, 0, 0, 1, 32'h302);
      do_br(0, 32'h300, 32'h80, 1, 1, 0, 0, 0, 1, 32'h304);
      do_br(0, 32'hFFFF_FFFE, 32'h80, 1, 1, 0, 0, 0, 1, 32'h2);
      // JAL never redirects; JALR ignores bit0.
      do_br(1, 32'h400, 32'h20, 1, 0, 0, 0, 0, 0, 0);
      do_br(2, 32'h500, 0, 1, 0, 0, 32'h1001, 32'h1000, 0, 0);
      do_br(2, 32'h500, 0, 1, 0, 0, 32'h1001, 32'h2000, 1, 32'h1000);
      // No decode flag: accepted but neither counted nor flushed.
      do_br(3, 32'h600, 32'h10, 1, 0, 1, 0, 0, 0, 0);

      // Kill together with ready in FLUSH, then kill held in IDLE.
      clear_inputs();
      i_valid = 1; i_bxx = 1; i_pc = 32'h700; i_prdt_taken = 1; i_cmp_res = 0; i_ilen32 = 1;
      cycle();
      clear_inputs();
      i_kill = 1; flush_req_ready = 1;
      cycle();
      flush_req_ready = 0;
      check("kill_valid", flush_req_valid, 1'b0);
      i_valid = 1; i_bxx = 1; i_prdt_taken = 1; i_cmp_res = 0;
      for (int k = 0; k < 2; k++) cycle();
      check("kill_idle_mispr", mispr_cnt, m_mis);
      check("kill_idle_valid", flush_req_valid, 1'b0);

      // Drive the mispredict counter into saturation and one step past it.
      for (int k = 0; k <= int'(CNT_MAX); k++)
         do_br(0, 32'h800, 32'h10, 1, 0, 1, 0, 0, 1, 32'h810);
      check("sat_mispr", mispr_cnt, CNT_MAX);
      check("sat_br", br_cnt, CNT_MAX);

      // Reset while a redirect is outstanding.
      clear_inputs();
      i_valid = 1; i_jalr = 1; i_jalr_tgt = 32'h3000; i_prdt_tgt = 32'h4000;
      cycle();
      clear_inputs();
      rst = 1;
      cycle();
      rst = 0;
      check("rst_flush_valid", flush_req_valid, 1'b0);
      check("rst_flush_pc", flush_pc, '0);
      check("rst_pulse", cmt_mispred, 1'b0);
      check("rst_cnts", {br_cnt, mispr_cnt}, '0);

      // Randomized traffic.
      for (int n = 0; n < 3000; n++) begin
         int f;
         clear_inputs();
         i_valid = ($urandom_range(0, 3) != 0);
         f = $urandom_range(0, 7);
         i_bxx = (f < 4); i_jal = (f == 4); i_jalr = (f == 5 || f == 6);
         i_prdt_taken = $urandom_range(0, 1);
         i_cmp_res = $urandom_range(0, 1);
         i_pc = $urandom;
         i_bjp_imm = $urandom;
         i_ilen32 = $urandom_range(0, 1);
         i_jalr_tgt = $urandom;
         i_prdt_tgt = $urandom_range(0, 1) ? (i_jalr_tgt ^ 32'(($urandom_range(0, 1)))) : $urandom;
         i_kill = ($urandom_range(0, 7) == 0);
         flush_req_ready = $urandom_range(0, 1);
         rst = ($urandom_range(0, 199) == 0);
         cycle();
      end
      rst = 0;

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
